func_result_stage: RTL and testbench

Registered receive side of the PE function unit. It accepts the four result/carry pairs produced each cycle (add/sub, mult, shift, logic) and selects one by `CONF_ALU` class. Accepted results are buffered in a 2-entry queue and handed to the PE output network over a valid/ready handshake. A per-configuration result counter marks the final result of a stream with `OUT_LAST`.

---
 rtl/func_result_stage.sv | 169 ++++++++++++++++
 tb/tb_func_result_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_result_stage.sv
// Receive side of the PE function unit: selects one unit result by CONF_ALU class,
// buffers it in a 2-entry queue and hands it downstream with a stream-end marker.
`ifndef CONF_ALU_B
`define CONF_ALU_B 4
`endif
`ifndef CONF_ALU_ADD
`define CONF_ALU_ADD  4'd0
`endif
`ifndef CONF_ALU_SUB
`define CONF_ALU_SUB  4'd1
`endif
`ifndef CONF_ALU_MULT
`define CONF_ALU_MULT 4'd2
`endif
`ifndef CONF_ALU_SL
`define CONF_ALU_SL   4'd3
`endif
`ifndef CONF_ALU_SR
`define CONF_ALU_SR   4'd4
`endif
`ifndef CONF_ALU_SRA
`define CONF_ALU_SRA  4'd5
`endif

module func_result_stage #(
    parameter int WORD_W  = 16,
    parameter int CARRY_W = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [`CONF_ALU_B-1:0] CONF_ALU,
    input  logic [CNT_W-1:0]       CONF_CNT,
    input  logic                   START,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WORD_W-1:0]      ADD_SUB_OUT,
    input  logic [CARRY_W-1:0]     ADD_SUB_OUT_C,
    input  logic [WORD_W-1:0]      MULT_OUT,
    input  logic [CARRY_W-1:0]     MULT_OUT_C,
    input  logic [WORD_W-1:0]      SHIFT_OUT,
    input  logic [CARRY_W-1:0]     SHIFT_OUT_C,
    input  logic [WORD_W-1:0]      LOGIC_OUT,
    input  logic [CARRY_W-1:0]     LOGIC_OUT_C,
    output logic [WORD_W-1:0]      OUT_DATA,
    output logic [CARRY_W-1:0]     OUT_C,
    output logic                   OUT_LAST,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic               last;
        logic [CARRY_W-1:0] c;
        logic [WORD_W-1:0]  data;
    } entry_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   rem, rem_nxt;
    entry_t             q_head, q_tail, in_entry;
    logic [1:0]         count;
    logic               pop, push, rem_zero, wr_head;
    logic [WORD_W-1:0]  sel_data;
    logic [CARRY_W-1:0] sel_c;

    // Data and carry always come from the same unit.
    always_comb begin
        sel_data = LOGIC_OUT;
        sel_c    = LOGIC_OUT_C;
        case (CONF_ALU)
            `CONF_ALU_ADD, `CONF_ALU_SUB: begin
                sel_data = ADD_SUB_OUT;
                sel_c    = ADD_SUB_OUT_C;
            end
            `CONF_ALU_MULT: begin
                sel_data = MULT_OUT;
                sel_c    = MULT_OUT_C;
            end
            `CONF_ALU_SL, `CONF_ALU_SR, `CONF_ALU_SRA: begin
                sel_data = SHIFT_OUT;
                sel_c    = SHIFT_OUT_C;
            end
            default: begin
                sel_data = LOGIC_OUT;
                sel_c    = LOGIC_OUT_C;
            end
        endcase
    end

    assign OUT_VALID = (count != 2'd0);
    assign pop       = OUT_VALID & OUT_READY;
    assign IN_READY  = (state == RUN) & ((count != 2'd2) | pop);
    assign push      = IN_VALID & IN_READY;
    assign rem_zero  = (rem == '0);
    assign BUSY      = (state != IDLE);

    always_comb begin
        in_entry.last = rem_zero;
        in_entry.c    = sel_c;
        in_entry.data = sel_data;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = RUN;
                    rem_nxt   = CONF_CNT;
                end
            end
            RUN: begin
                if (push) begin
                    if (rem_zero) state_nxt = DRAIN;
                    else          rem_nxt   = rem - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (count == 2'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // A push lands in the head slot when the queue is, or is about to become, empty.
    assign wr_head = (count == 2'd0) | ((count == 2'd1) & pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_head <= '0;
            q_tail <= '0;
            count  <= 2'd0;
        end else begin
            if (pop && count == 2'd2) q_head <= q_tail;
            if (push) begin
                if (wr_head) q_head <= in_entry;
                else         q_tail <= in_entry;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign OUT_DATA = q_head.data;
    assign OUT_C    = q_head.c;
    assign OUT_LAST = q_head.last & OUT_VALID;

endmodule

// File: tb/tb_func_result_stage.sv
// Self-checking bench for func_result_stage: directed vector table, hand-written
// corner sequences and randomized traffic compared against a queue-based model.
module tb_func_result_stage;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MULT = 4'd2, SL = 4'd3,
                           SR = 4'd4, SRA = 4'd5, AND_ = 4'd6, EQL = 4'd9;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  CONF_ALU;
    logic [7:0]  CONF_CNT;
    logic        START, IN_VALID, IN_READY;
    logic [15:0] ADD_SUB_OUT, MULT_OUT, SHIFT_OUT, LOGIC_OUT;
    logic        ADD_SUB_OUT_C, MULT_OUT_C, SHIFT_OUT_C, LOGIC_OUT_C;
    logic [15:0] OUT_DATA;
    logic        OUT_C, OUT_LAST, OUT_VALID, OUT_READY, BUSY;

    func_result_stage #(.WORD_W(16), .CARRY_W(1), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CONF_ALU(CONF_ALU), .CONF_CNT(CONF_CNT),
        .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ADD_SUB_OUT(ADD_SUB_OUT), .ADD_SUB_OUT_C(ADD_SUB_OUT_C),
        .MULT_OUT(MULT_OUT), .MULT_OUT_C(MULT_OUT_C),
        .SHIFT_OUT(SHIFT_OUT), .SHIFT_OUT_C(SHIFT_OUT_C),
        .LOGIC_OUT(LOGIC_OUT), .LOGIC_OUT_C(LOGIC_OUT_C),
        .OUT_DATA(OUT_DATA), .OUT_C(OUT_C), .OUT_LAST(OUT_LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        last;
    } ent_t;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp_d;
        logic        exp_c;
    } vec_t;

    int   cmp  = 0;
    int   errs = 0;
    ent_t mq[$];
    int   mmode = 0;  // 0 idle, 1 accepting, 2 draining
    int   mrem  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void unit_of(input logic [3:0] code, output logic [15:0] d, output logic c);
        if (code == ADD || code == SUB) begin
            d = ADD_SUB_OUT; c = ADD_SUB_OUT_C;
        end else if (code == MULT) begin
            d = MULT_OUT; c = MULT_OUT_C;
        end else if (code == SL || code == SR || code == SRA) begin
            d = SHIFT_OUT; c = SHIFT_OUT_C;
        end else begin
            d = LOGIC_OUT; c = LOGIC_OUT_C;
        end
    endfunction

    // Called at posedge+1 with inputs already driven; returns whether a result was accepted.
    task automatic cycle(output bit acc);
        bit   pop;
        int   sz;
        ent_t e;
        #1;
        sz  = mq.size();
        pop = (sz > 0) && OUT_READY;
        check("in_ready", {31'b0, IN_READY}, {31'b0, (mmode == 1) && (sz < 2 || pop)});
        acc = (mmode == 1) && IN_VALID && (sz < 2 || pop);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            unit_of(CONF_ALU, e.d, e.c);
            e.last = (mrem == 0);
            mq.push_back(e);
            if (mrem == 0) mmode = 2;
            else           mrem = mrem - 1;
        end else if (mmode == 0 && START) begin
            mmode = 1;
            mrem  = CONF_CNT;
        end else if (mmode == 2 && sz == 0) begin
            mmode = 0;
        end
        @(posedge CLK);
        #1;
        check("out_valid", {31'b0, OUT_VALID}, {31'b0, mq.size() > 0});
        check("busy", {31'b0, BUSY}, {31'b0, mmode != 0});
        if (mq.size() > 0) begin
            check("out_data", {16'b0, OUT_DATA}, {16'b0, mq[0].d});
            check("out_c", {31'b0, OUT_C}, {31'b0, mq[0].c});
            check("out_last", {31'b0, OUT_LAST}, {31'b0, mq[0].last});
        end
    endtask

    task automatic start_stream(input logic [3:0] code, input logic [7:0] cnt);
        bit acc;
        CONF_ALU = code;
        CONF_CNT = cnt;
        START    = 1'b1;
        IN_VALID = 1'b0;
        cycle(acc);
        START = 1'b0;
    endtask

    task automatic drain_to_idle();
        bit acc;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 10 && mmode != 0; i++) cycle(acc);
        check("drain_timeout", {31'b0, mmode != 0}, 32'd0);
    endtask

    vec_t vecs[8];
    bit   acc;
    int   val;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; CONF_ALU = '0; CONF_CNT = '0; START = 1'b0; IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        ADD_SUB_OUT = '0; MULT_OUT = '0; SHIFT_OUT = '0; LOGIC_OUT = '0;
        ADD_SUB_OUT_C = 1'b0; MULT_OUT_C = 1'b0; SHIFT_OUT_C = 1'b0; LOGIC_OUT_C = 1'b0;

        vecs[0] = '{ADD,  16'h1111, 1'b1};
        vecs[1] = '{SUB,  16'h1111, 1'b1};
        vecs[2] = '{MULT, 16'h2222, 1'b0};
        vecs[3] = '{SL,   16'h3333, 1'b1};
        vecs[4] = '{SR,   16'h3333, 1'b1};
        vecs[5] = '{SRA,  16'h3333, 1'b1};
        vecs[6] = '{AND_, 16'h4444, 1'b0};
        vecs[7] = '{EQL,  16'h4444, 1'b0};

        #2;
        check("rst_out_data", {16'b0, OUT_DATA}, 32'd0);
        check("rst_out_c", {31'b0, OUT_C}, 32'd0);
        check("rst_out_last", {31'b0, OUT_LAST}, 32'd0);
        check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_in_ready", {31'b0, IN_READY}, 32'd0);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        repeat (2) @(posedge CLK);
        #5 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Basic add stream
        MULT_OUT = 16'hFFFF;
        start_stream(ADD, 8'd2);
        IN_VALID = 1'b1; OUT_READY = 1'b1; val = 1;
        for (int i = 0; i < 20 && val < 4; i++) begin
            ADD_SUB_OUT = 16'(val);
            cycle(acc);
            if (acc) val++;
        end
        check("basic_accepts", val, 32'd4);
        check("basic_head3", {16'b0, OUT_DATA}, 32'h3);
        check("basic_last3", {31'b0, OUT_LAST}, 32'd1);
        drain_to_idle();

        // Unit select table
        ADD_SUB_OUT = 16'h1111; MULT_OUT = 16'h2222; SHIFT_OUT = 16'h3333; LOGIC_OUT = 16'h4444;
        ADD_SUB_OUT_C = 1'b1; MULT_OUT_C = 1'b0; SHIFT_OUT_C = 1'b1; LOGIC_OUT_C = 1'b0;
        for (int v = 0; v < 8; v++) begin
            start_stream(vecs[v].code, 8'd0);
            IN_VALID = 1'b1; OUT_READY = 1'b0;
            cycle(acc);
            check("sel_accept", {31'b0, acc}, 32'd1);
            check("sel_data", {16'b0, OUT_DATA}, {16'b0, vecs[v].exp_d});
            check("sel_c", {31'b0, OUT_C}, {31'b0, vecs[v].exp_c});
            drain_to_idle();
        end

        // Backpressure: two accepts fill the queue, then pop+push at full
        start_stream(ADD, 8'd3);
        IN_VALID = 1'b1; OUT_READY = 1'b0; val = 1;
        for (int i = 0; i < 4; i++) begin
            ADD_SUB_OUT = 16'(val);
            cycle(acc);
            if (acc) val++;
        end
        check("bp_accepts", val, 32'd3);
        check("bp_head", {16'b0, OUT_DATA}, 32'h1);
        OUT_READY = 1'b1;
        ADD_SUB_OUT = 16'(val);
        #1;
        check("bp_passthru_ready", {31'b0, IN_READY}, 32'd1);
        for (int i = 0; i < 20 && val < 5; i++) begin
            ADD_SUB_OUT = 16'(val);
            cycle(acc);
            if (acc) val++;
        end
        check("bp_total", val, 32'd5);
        drain_to_idle();

        // Single-result stream with a START during DRAIN
        start_stream(MULT, 8'd0);
        IN_VALID = 1'b1; OUT_READY = 1'b0;
        cycle(acc);
        IN_VALID = 1'b0; START = 1'b1; CONF_CNT = 8'd7;
        cycle(acc);
        START = 1'b0;
        check("single_last", {31'b0, OUT_LAST}, 32'd1);
        drain_to_idle();
        cycle(acc);
        check("single_stay_idle", {31'b0, BUSY}, 32'd0);

        // Asynchronous reset with two queued entries
        start_stream(ADD, 8'd5);
        IN_VALID = 1'b1; OUT_READY = 1'b0;
        repeat (3) cycle(acc);
        check("mid_queued", {31'b0, OUT_VALID}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, OUT_VALID}, 32'd0);
        check("mid_rst_busy", {31'b0, BUSY}, 32'd0);
        check("mid_rst_ready", {31'b0, IN_READY}, 32'd0);
        mq.delete(); mmode = 0; mrem = 0;
        #1 RST_N = 1'b1;
        repeat (3) cycle(acc);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (mmode == 0) begin
                CONF_ALU = 4'($urandom_range(0, 15));
                CONF_CNT = 8'($urandom_range(0, 5));
                START    = ($urandom_range(0, 3) == 0);
            end else begin
                START = ($urandom_range(0, 15) == 0);
            end
            IN_VALID      = ($urandom_range(0, 9) < 7);
            OUT_READY     = ($urandom_range(0, 9) < 6);
            ADD_SUB_OUT   = 16'($urandom);
            MULT_OUT      = 16'($urandom);
            SHIFT_OUT     = 16'($urandom);
            LOGIC_OUT     = 16'($urandom);
            ADD_SUB_OUT_C = 1'($urandom);
            MULT_OUT_C    = 1'($urandom);
            SHIFT_OUT_C   = 1'($urandom);
            LOGIC_OUT_C   = 1'($urandom);
            cycle(acc);
        end
        START = 1'b0;
        drain_to_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
